// File: rtl/rv_pkg.sv
// ============================================================================
// Module   : rv_pkg
// Purpose  : Shared types for the data-memory arbiter: arbitration mode enum
//            and the packed memory request record.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

    localparam int XLEN = 32;

    // Arbitration mode of the starvation FSM.
    typedef enum logic [0:0] {
        PRI_M0   = 1'b0,
        FORCE_M1 = 1'b1
    } arb_mode_e;

    // One memory request, used for both master inputs and the memory port.
    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic              wen;
        logic [XLEN/8-1:0] wstrb;
        logic [XLEN-1:0]   wdata;
    } dmem_req_t;

endpackage

`default_nettype wire

// File: rtl/rv_arb_starve_ctr.sv
// ============================================================================
// Module   : rv_arb_starve_ctr
// Purpose  : Saturating count of consecutive cycles master 1 was denied, plus
//            the two-state priority FSM that forces master 1 to win once the
//            count reaches STARVE_MAX. Legal STARVE_MAX range is 1..15.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_arb_starve_ctr #(
    parameter  int STARVE_MAX = 4,
    localparam int CW         = $clog2(STARVE_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m1_req,
    input  logic          gnt1,
    output logic          force_m1,
    output logic [CW-1:0] starve_cnt
);
    import rv_pkg::*;

    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    arb_mode_e mode;
    arb_mode_e mode_next;
    logic      deny;

    // Master 1 is waiting this cycle: it asked and lost.
    assign deny = m1_req && !gnt1;

    // Denied-cycle counter: count up to the limit, clear whenever m1 is
    // served or stops asking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (deny) begin
            if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // Priority mode register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode <= PRI_M0;
        end else begin
            mode <= mode_next;
        end
    end

    // Enter FORCE_M1 on the denial that brings the count to the limit; leave
    // as soon as m1 is served or withdraws.
    always_comb begin
        mode_next = mode;
        case (mode)
            PRI_M0: begin
                if (deny && (starve_cnt == CNT_MAX - 1'b1)) begin
                    mode_next = FORCE_M1;
                end
            end
            FORCE_M1: begin
                if (gnt1 || !m1_req) begin
                    mode_next = PRI_M0;
                end
            end
            default: mode_next = PRI_M0;
        endcase
    end

    // Mode decode for the grant logic.
    always_comb begin
        force_m1 = (mode == FORCE_M1);
    end

endmodule

`default_nettype wire

// File: rtl/rv_dmem_arb.sv
// ============================================================================
// Module   : rv_dmem_arb
// Purpose  : Two-master arbiter for the single-port data memory. Master 0 has
//            fixed priority; master 1 is guaranteed service after STARVE_MAX
//            consecutive denials. Grants and the memory mux are combinational,
//            read data and read-valid are registered one cycle after grant.
//            XLEN must equal rv_pkg::XLEN (the request record is sized by it).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_dmem_arb #(
    parameter int XLEN       = rv_pkg::XLEN,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_arb_clk,
    input  logic              i_arb_rst,
    input  logic              i_arb_m0_req,
    input  logic [XLEN-1:0]   i_arb_m0_addr,
    input  logic              i_arb_m0_wen,
    input  logic [XLEN/8-1:0] i_arb_m0_wstrb,
    input  logic [XLEN-1:0]   i_arb_m0_wdata,
    output logic              o_arb_m0_gnt,
    output logic              o_arb_m0_rvalid,
    output logic [XLEN-1:0]   o_arb_m0_rdata,
    input  logic              i_arb_m1_req,
    input  logic [XLEN-1:0]   i_arb_m1_addr,
    input  logic              i_arb_m1_wen,
    input  logic [XLEN/8-1:0] i_arb_m1_wstrb,
    input  logic [XLEN-1:0]   i_arb_m1_wdata,
    output logic              o_arb_m1_gnt,
    output logic              o_arb_m1_rvalid,
    output logic [XLEN-1:0]   o_arb_m1_rdata,
    output logic [XLEN-1:0]   o_arb_dmem_addr,
    output logic              o_arb_dmem_wen,
    output logic [XLEN/8-1:0] o_arb_dmem_wstrb,
    output logic [XLEN-1:0]   o_arb_dmem_wdata,
    input  logic [XLEN-1:0]   i_arb_dmem_rdata
);
    import rv_pkg::*;

    localparam int CW = $clog2(STARVE_MAX + 1);

    dmem_req_t     m0_bus;
    dmem_req_t     m1_bus;
    dmem_req_t     mem_bus;
    logic          gnt0;
    logic          gnt1;
    logic          force_m1;
    logic [CW-1:0] starve_cnt;

    assign m0_bus = '{addr: i_arb_m0_addr, wen: i_arb_m0_wen,
                      wstrb: i_arb_m0_wstrb, wdata: i_arb_m0_wdata};
    assign m1_bus = '{addr: i_arb_m1_addr, wen: i_arb_m1_wen,
                      wstrb: i_arb_m1_wstrb, wdata: i_arb_m1_wdata};

    // m1 wins when alone or when forced; m0 takes anything m1 did not win.
    assign gnt1 = i_arb_m1_req && (!i_arb_m0_req || force_m1);
    assign gnt0 = i_arb_m0_req && !gnt1;

    assign o_arb_m0_gnt = gnt0;
    assign o_arb_m1_gnt = gnt1;

    rv_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_ctr (
        .clk        (i_arb_clk),
        .rst        (i_arb_rst),
        .m1_req     (i_arb_m1_req),
        .gnt1       (gnt1),
        .force_m1   (force_m1),
        .starve_cnt (starve_cnt)
    );

    // Route the granted master to memory; an idle port is driven all-zero so
    // memory can never see a stray write.
    always_comb begin
        mem_bus = '0;
        if (gnt0) begin
            mem_bus = m0_bus;
        end else if (gnt1) begin
            mem_bus = m1_bus;
        end
    end

    assign o_arb_dmem_addr  = mem_bus.addr;
    assign o_arb_dmem_wen   = mem_bus.wen;
    assign o_arb_dmem_wstrb = mem_bus.wstrb;
    assign o_arb_dmem_wdata = mem_bus.wdata;

    // Capture read data for the granted reader; rvalid is a one-cycle pulse
    // per granted read and rdata holds between reads.
    always_ff @(posedge i_arb_clk or posedge i_arb_rst) begin
        if (i_arb_rst) begin
            o_arb_m0_rvalid <= 1'b0;
            o_arb_m1_rvalid <= 1'b0;
            o_arb_m0_rdata  <= '0;
            o_arb_m1_rdata  <= '0;
        end else begin
            o_arb_m0_rvalid <= gnt0 && !i_arb_m0_wen;
            o_arb_m1_rvalid <= gnt1 && !i_arb_m1_wen;
            if (gnt0 && !i_arb_m0_wen) begin
                o_arb_m0_rdata <= i_arb_dmem_rdata;
            end
            if (gnt1 && !i_arb_m1_wen) begin
                o_arb_m1_rdata <= i_arb_dmem_rdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rv_dmem_arb.sv
// ============================================================================
// Module   : tb_rv_dmem_arb
// Purpose  : Self-checking bench for rv_dmem_arb: table of grant/counter
//            vectors, hand-written corner sequences and a randomized run
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_dmem_arb;
    import rv_pkg::*;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_load = 1'b1;

    logic        m0_req, m0_wen, m1_req, m1_wen;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        gnt0, gnt1, rv0, rv1;
    logic [31:0] rd0, rd1;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_wen;
    logic [3:0]  dmem_wstrb;

    int passed = 0;
    int total  = 0;

    // Memory seen by the DUT and the model's private copy of it.
    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];

    // Reference model state.
    int          m1_wait;
    logic        ev0, ev1;
    logic [31:0] ed0, ed1;
    logic        eg0, eg1;

    rv_dmem_arb #(.XLEN(32), .STARVE_MAX(SM)) dut (
        .i_arb_clk        (clk),
        .i_arb_rst        (rst),
        .i_arb_m0_req     (m0_req),
        .i_arb_m0_addr    (m0_addr),
        .i_arb_m0_wen     (m0_wen),
        .i_arb_m0_wstrb   (m0_wstrb),
        .i_arb_m0_wdata   (m0_wdata),
        .o_arb_m0_gnt     (gnt0),
        .o_arb_m0_rvalid  (rv0),
        .o_arb_m0_rdata   (rd0),
        .i_arb_m1_req     (m1_req),
        .i_arb_m1_addr    (m1_addr),
        .i_arb_m1_wen     (m1_wen),
        .i_arb_m1_wstrb   (m1_wstrb),
        .i_arb_m1_wdata   (m1_wdata),
        .o_arb_m1_gnt     (gnt1),
        .o_arb_m1_rvalid  (rv1),
        .o_arb_m1_rdata   (rd1),
        .o_arb_dmem_addr  (dmem_addr),
        .o_arb_dmem_wen   (dmem_wen),
        .o_arb_dmem_wstrb (dmem_wstrb),
        .o_arb_dmem_wdata (dmem_wdata),
        .i_arb_dmem_rdata (dmem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'hDEAD_BEEF;
        return 32'hA5A5_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    // Combinational-read memory with byte-strobed writes at the clock edge.
    assign dmem_rdata = mem[dmem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (dmem_wen) begin
            for (int b = 0; b < 4; b++)
                if (dmem_wstrb[b]) mem[dmem_addr[7:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input int m, input logic req, input logic [31:0] addr,
                         input logic wen, input logic [3:0] strb, input logic [31:0] data);
        if (m == 0) begin
            m0_req = req; m0_addr = addr; m0_wen = wen; m0_wstrb = strb; m0_wdata = data;
        end else begin
            m1_req = req; m1_addr = addr; m1_wen = wen; m1_wstrb = strb; m1_wdata = data;
        end
    endtask

    task automatic idle();
        drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        drive(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    endtask

    // Called just before the active edge: compare DUT to model, then advance
    // the model across the edge.
    task automatic model_step();
        logic [31:0] ea, ed;
        logic        ew;
        logic [3:0]  es;
        eg1 = m1_req && (!m0_req || m1_wait >= SM);
        eg0 = m0_req && !eg1;
        ea = 32'h0; ew = 1'b0; es = 4'h0; ed = 32'h0;
        if (eg0) begin ea = m0_addr; ew = m0_wen; es = m0_wstrb; ed = m0_wdata; end
        else if (eg1) begin ea = m1_addr; ew = m1_wen; es = m1_wstrb; ed = m1_wdata; end
        chk("gnt0", 32'(gnt0), 32'(eg0));
        chk("gnt1", 32'(gnt1), 32'(eg1));
        chk("dmem_addr", dmem_addr, ea);
        chk("dmem_wen", 32'(dmem_wen), 32'(ew));
        chk("dmem_wstrb", 32'(dmem_wstrb), 32'(es));
        chk("dmem_wdata", dmem_wdata, ed);
        chk("m0_rvalid", 32'(rv0), 32'(ev0));
        chk("m1_rvalid", 32'(rv1), 32'(ev1));
        chk("m0_rdata", rd0, ed0);
        chk("m1_rdata", rd1, ed1);
        chk("starve_cnt", 32'(dut.u_ctr.starve_cnt), 32'(m1_wait));
        chk("mode", 32'(dut.u_ctr.mode), (m1_wait == SM) ? 32'(FORCE_M1) : 32'(PRI_M0));
        // Advance across the edge.
        ev0 = eg0 && !m0_wen;
        ev1 = eg1 && !m1_wen;
        if (ev0) ed0 = ref_mem[m0_addr[7:2]];
        if (ev1) ed1 = ref_mem[m1_addr[7:2]];
        if (ew) begin
            for (int b = 0; b < 4; b++)
                if (es[b]) ref_mem[ea[7:2]][8*b +: 8] = ed[8*b +: 8];
        end
        if (m1_req && !eg1) m1_wait = (m1_wait < SM) ? m1_wait + 1 : SM;
        else m1_wait = 0;
    endtask

    task automatic run_cycle();
        @(negedge clk);
        model_step();
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic m0, m1;
        logic g0, g1;
        int   cnt;
    } vec_t;

    vec_t vecs [14];
    logic [31:0] tmp;
    logic        p0, p1;
    int          cnt_hist [5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Starvation pattern from a clean state, then single-master and idle rows.
        for (int i = 0; i < 10; i++) vecs[i] = '{1'b1, 1'b1, (i % 5) != 4, (i % 5) == 4, i % 5};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 0};

        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        m1_wait = 0; ev0 = 1'b0; ev1 = 1'b0; ed0 = 32'h0; ed1 = 32'h0;
        idle();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset m0_rvalid", 32'(rv0), 32'h0);
        chk("reset m1_rvalid", 32'(rv1), 32'h0);
        chk("reset m0_rdata", rd0, 32'h0);
        chk("reset m1_rdata", rd1, 32'h0);
        chk("reset starve_cnt", 32'(dut.u_ctr.starve_cnt), 32'h0);
        chk("reset mode", 32'(dut.u_ctr.mode), 32'(PRI_M0));
        rst = 1'b0; mem_load = 1'b0;
        run_cycle();  // idle

        // Single read by m0.
        drive(0, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        chk("read gnt0", 32'(gnt0), 32'h1);
        model_step();
        @(posedge clk); #1;
        chk("read rvalid0", 32'(rv0), 32'h1);
        chk("read rdata0", rd0, 32'hDEAD_BEEF);
        chk("read rvalid1", 32'(rv1), 32'h0);
        idle();
        run_cycle();

        // Partial write by m1, then readback by m0.
        drive(1, 1'b1, 32'h20, 1'b1, 4'b0011, 32'h1234_5678);
        @(negedge clk);
        chk("write dmem_wen", 32'(dmem_wen), 32'h1);
        model_step();
        @(posedge clk); #1;
        chk("write no rvalid1", 32'(rv1), 32'h0);
        idle();
        drive(0, 1'b1, 32'h20, 1'b0, 4'h0, 32'h0);
        run_cycle();
        tmp = init_word(8);
        chk("write readback", rd0, {tmp[31:16], 16'h5678});
        idle();
        run_cycle();

        // Table: grant pattern and counter value per cycle.
        for (int i = 0; i < 14; i++) begin
            drive(0, vecs[i].m0, 32'h30, 1'b0, 4'h0, 32'h0);
            drive(1, vecs[i].m1, 32'h34, 1'b0, 4'h0, 32'h0);
            @(negedge clk);
            chk($sformatf("vec%0d gnt0", i), 32'(gnt0), 32'(vecs[i].g0));
            chk($sformatf("vec%0d gnt1", i), 32'(gnt1), 32'(vecs[i].g1));
            chk($sformatf("vec%0d cnt", i), 32'(dut.u_ctr.starve_cnt), 32'(vecs[i].cnt));
            if (!vecs[i].m0 && !vecs[i].m1) begin
                chk("idle wen", 32'(dmem_wen), 32'h0);
                chk("idle wstrb", 32'(dmem_wstrb), 32'h0);
                chk("idle addr", dmem_addr, 32'h0);
            end
            model_step();
            @(posedge clk); #1;
        end
        idle();
        run_cycle();

        // Drop after two denials clears the count; m1 waits four more cycles.
        drive(0, 1'b1, 32'h40, 1'b0, 4'h0, 32'h0);
        drive(1, 1'b1, 32'h44, 1'b0, 4'h0, 32'h0);
        run_cycle();
        run_cycle();
        drive(1, 1'b0, 32'h44, 1'b0, 4'h0, 32'h0);
        run_cycle();
        drive(1, 1'b1, 32'h44, 1'b0, 4'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("drop gnt1 %0d", i), 32'(gnt1), (i == 4) ? 32'h1 : 32'h0);
            model_step();
            @(posedge clk); #1;
        end
        idle();
        run_cycle();

        // Reset during a forced m1 read.
        drive(0, 1'b1, 32'h50, 1'b0, 4'h0, 32'h0);
        drive(1, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
        repeat (4) run_cycle();
        #2 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst m0_rvalid", 32'(rv0), 32'h0);
        chk("rst m1_rvalid", 32'(rv1), 32'h0);
        chk("rst m1_rdata", rd1, 32'h0);
        chk("rst mode", 32'(dut.u_ctr.mode), 32'(PRI_M0));
        chk("rst starve_cnt", 32'(dut.u_ctr.starve_cnt), 32'h0);
        idle();
        #1 rst = 1'b0;
        ev0 = 1'b0; ev1 = 1'b0; ed0 = 32'h0; ed1 = 32'h0; m1_wait = 0;
        run_cycle();

        // Randomized traffic; each master holds its request until granted.
        p0 = 1'b0; p1 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!p0) begin
                p0 = ($urandom_range(0, 3) != 0);
                drive(0, p0, {24'h0, 6'($urandom), 2'b00}, 1'($urandom),
                      4'($urandom), $urandom);
            end
            if (!p1) begin
                p1 = ($urandom_range(0, 1) != 0);
                drive(1, p1, {24'h0, 6'($urandom), 2'b00}, 1'($urandom),
                      4'($urandom), $urandom);
            end
            run_cycle();
            if (eg0) p0 = 1'b0;
            if (eg1) p1 = 1'b0;
            if (!p0) m0_req = 1'b0;
            if (!p1) m1_req = 1'b0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
